ha_serial_seq: RTL and testbench

Bit-serial adder sequencer built around a single shared half-adder cell pair. It latches two WIDTH-bit operands on a start request and walks them LSB-first through the half-adder datapath, one bit per enabled clock. A carry register chains the bits. It delivers a WIDTH-bit sum and carry-out with a one-cycle done pulse. It sits between the user-project pin logic and the half-adder datapath, and is the only block that drives that datapath.

---
 rtl/ha_serial_seq.sv | 147 ++++++++++++++
 tb/tb_ha_serial_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ha_serial_seq.sv
// ha_serial_seq: bit-serial adder sequencer driving one shared half-adder pair.
// Operands are latched on start and processed LSB-first, one bit per enabled clock.
// Optional feature macro: HA_SEQ_SUB_EN enables A-B via A+~B+1 when sub=1 at start.
// With the macro undefined, sub is ignored and every operation is an addition.
module ha_serial_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Operand B and carry-in as loaded at start
    logic [WIDTH-1:0] b_load;
    logic             cin_load;

`ifdef HA_SEQ_SUB_EN
    // Subtraction reuses the adder: invert B and inject a carry-in of one
    always_comb begin
        b_load   = sub ? ~b : b;
        cin_load = sub;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;

    // Addition only: B passes straight through with no carry-in
    always_comb begin
        b_load   = b;
        cin_load = 1'b0;
    end
`endif

    // Two chained half adders on the current LSBs
    logic s1, c1, s_bit, c2;
    always_comb begin
        s1    = sa_q[0] ^ sb_q[0];
        c1    = sa_q[0] & sb_q[0];
        s_bit = s1 ^ carry_q;
        c2    = s1 & carry_q;
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = done_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (start) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    sa_d    = a;
                    sb_d    = b_load;
                    carry_d = cin_load;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            StRun: begin
                carry_d = c1 | c2;
                cout_d  = c1 | c2;
                sum_d   = {s_bit, sum_q[WIDTH-1:1]};
                sa_d    = {1'b0, sa_q[WIDTH-1:1]};
                sb_d    = {1'b0, sb_q[WIDTH-1:1]};
                if (cnt_q == CntLast) begin
                    // Last bit: leave RUN without letting cnt wrap
                    state_d = StDone;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers; everything freezes while ena is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (ena) begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_ha_serial_seq.sv
// Testbench for ha_serial_seq (WIDTH=8): table vectors, corner sequences and random ops.
module tb_ha_serial_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ena = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int tests = 0;
    int fails = 0;

    ha_serial_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, {cout, sum}
    function automatic logic [W:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic sv);
        int unsigned r;
`ifdef HA_SEQ_SUB_EN
        if (sv) begin
            r = (int'(av) - int'(bv)) & ((1 << W) - 1);
            return {(av >= bv), r[W-1:0]};
        end
`endif
        r = int'(av) + int'(bv);
        return r[W:0];
    endfunction

    // One operation; optional ena stall before enabled edge stall_at, optional
    // ignored start pulse (a=b=0) on RUN edge 3.
    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                      input int stall_at, input int stall_n, input bit poke,
                      input logic [W-1:0] es, input logic ec);
        @(negedge clk);
        ena = 1'b1; a = av; b = bv; sub = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("e0_busy", busy, 1);
        for (int k = 1; k <= W + 1; k++) begin
            if (k == stall_at) begin
                ena = 1'b0;
                repeat (stall_n) begin
                    @(posedge clk); #1;
                    check("stall_busy", busy, (k - 1 < W));
                    check("stall_done", done, (k - 1 == W));
                end
                ena = 1'b1;
            end
            if (poke && k == 3) begin
                start = 1'b1; a = '0; b = '0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("run_busy", busy, (k < W));
            check("run_done", done, (k == W));
            if (k >= W) begin
                check("sum", sum, es);
                check("cout", cout, ec);
            end
        end
    endtask

    initial begin : main
        logic [W:0] m;
        logic [W-1:0] ra, rb;
        logic rs;
        int st, to;
        bit seen;

        tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1};
        tbl[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[4] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0};
`ifdef HA_SEQ_SUB_EN
        tbl[5] = '{8'h10, 8'h20, 1'b1, 8'hF0, 1'b0};
        tbl[6] = '{8'h20, 8'h10, 1'b1, 8'h10, 1'b1};
`else
        tbl[5] = '{8'h10, 8'h20, 1'b1, 8'h30, 1'b0};
        tbl[6] = '{8'h20, 8'h10, 1'b1, 8'h30, 1'b0};
`endif

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors: row 0 gets the ignored start, row 1 a stall while done is
        // high, row 3 a five-cycle mid-RUN stall
        for (int i = 0; i < 7; i++) begin
            op(tbl[i].a, tbl[i].b, tbl[i].sub,
               (i == 3) ? 4 : ((i == 1) ? W + 1 : 0),
               (i == 1) ? 3 : 5, (i == 0), tbl[i].s, tbl[i].c);
        end

        // Reset mid-RUN: outputs clear at once, no done follows
        @(negedge clk);
        a = 8'hAB; b = 8'hCD; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_sum", sum, 0);
        check("arst_cout", cout, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("arst_no_done", seen, 0);

        // start held high: re-accepted on the cycle after DONE
        @(negedge clk);
        a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 8'h40; b = 8'h41;
        to = 0;
        while (!done && to < 4 * W) begin
            @(posedge clk); #1;
            to++;
        end
        check("b2b_first_done", done, 1);
        check("b2b_first_sum", sum, 8'h03);
        @(posedge clk); #1;
        check("b2b_idle_busy", busy, 0);
        @(posedge clk); #1;
        check("b2b_reaccept_busy", busy, 1);
        start = 1'b0;
        to = 0;
        while (!done && to < 4 * W) begin
            @(posedge clk); #1;
            to++;
        end
        check("b2b_second_done", done, 1);
        check("b2b_second_sum", sum, 8'h81);
        check("b2b_second_cout", cout, 0);
        @(posedge clk); #1;

        // Random operations against the arithmetic model
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W + 1)) : 0;
            m = model(ra, rb, rs);
            op(ra, rb, rs, st, int'($urandom_range(1, 3)), 1'b0, m[W-1:0], m[W]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, timeout expected none");
        $fatal(1);
    end

endmodule
